// File: rtl/primitive_io_sequencer.sv
// primitive_io_sequencer
//   Power-up sequencer and round-robin capture arbiter for a bank of
//   I_BUF -> DFFRE -> O_BUF_DS input capture channels.
//
//   Sequence: IDLE -> RESET (ff_rst held) -> ENABLE (I_BUFs switched on one at
//   a time, SETTLE_CYCLES apart) -> RUN (one DFFRE strobed per cycle) ->
//   SHUTDOWN (I_BUFs switched off top-down) -> IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      pulse, begins power-up from IDLE
//   stop       pulse, begins shutdown from RESET/ENABLE/RUN
//   cap_req    per-channel level capture requests
//   ibuf_en    I_BUF EN pins
//   ff_rst     DFFRE R pins (all channels), active-high
//   ff_en      DFFRE E pins, one-hot or zero; doubles as the grant
//   ready      high while in RUN
//   busy       high whenever not IDLE
//   cap_count  grant counter, only with PRIMITIVE_IO_SEQ_CAPCNT_EN defined
//
// Optional feature macro: PRIMITIVE_IO_SEQ_CAPCNT_EN
module primitive_io_sequencer #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned RST_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] cap_req,
    output logic [NUM_CH-1:0] ibuf_en,
    output logic              ff_rst,
    output logic [NUM_CH-1:0] ff_en,
    output logic              ready,
    output logic              busy
`ifdef PRIMITIVE_IO_SEQ_CAPCNT_EN
    ,
    output logic [15:0]       cap_count
`endif
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ENABLE,
        S_RUN,
        S_SHUTDOWN
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] ibuf_en_q, ibuf_en_d;
    logic [NUM_CH-1:0] ff_en_q, ff_en_d;
    logic              ff_rst_q, ff_rst_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              found;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        ibuf_en_d = ibuf_en_q;
        ff_en_d   = '0;
        found     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_RESET;
            end
            S_RESET: begin
                if (stop) begin
                    state_d = S_SHUTDOWN;
                end else if (cnt_q == 8'(RST_CYCLES - 1)) begin
                    state_d   = S_ENABLE;
                    ibuf_en_d = NUM_CH'(1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ENABLE: begin
                if (stop) begin
                    state_d   = S_SHUTDOWN;
                    ibuf_en_d = ibuf_en_q >> 1;
                end else if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (ibuf_en_q[NUM_CH-1]) state_d = S_RUN;
                    else ibuf_en_d = (ibuf_en_q << 1) | NUM_CH'(1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d   = S_SHUTDOWN;
                    ibuf_en_d = ibuf_en_q >> 1;
                end else begin
                    // Rotating priority split into two linear passes: first
                    // channels at/after rr_ptr, then the wrapped low channels.
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (!found && i >= 32'(rr_ptr_q) && cap_req[i] && !ff_en_q[i]) begin
                            found      = 1'b1;
                            ff_en_d[i] = 1'b1;
                            rr_ptr_d   = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
                        end
                    end
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (!found && cap_req[i] && !ff_en_q[i]) begin
                            found      = 1'b1;
                            ff_en_d[i] = 1'b1;
                            rr_ptr_d   = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
                        end
                    end
                end
            end
            S_SHUTDOWN: begin
                // ibuf_en is always a contiguous run from bit 0, so a right
                // shift clears the highest set bit.
                if (ibuf_en_q == '0) state_d = S_IDLE;
                else ibuf_en_d = ibuf_en_q >> 1;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;

        ff_rst_d = !(state_d == S_ENABLE || state_d == S_RUN);
        ready_d  = (state_d == S_RUN);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            ibuf_en_q <= '0;
            ff_en_q   <= '0;
            ff_rst_q  <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            ibuf_en_q <= ibuf_en_d;
            ff_en_q   <= ff_en_d;
            ff_rst_q  <= ff_rst_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ibuf_en = ibuf_en_q;
    assign ff_en   = ff_en_q;
    assign ff_rst  = ff_rst_q;
    assign ready   = ready_q;
    assign busy    = busy_q;

`ifdef PRIMITIVE_IO_SEQ_CAPCNT_EN
    logic [15:0] cap_count_q, cap_count_d;

    always_comb begin
        cap_count_d = (ff_en_q != '0) ? cap_count_q + 16'd1 : cap_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cap_count_q <= '0;
        else      cap_count_q <= cap_count_d;
    end

    assign cap_count = cap_count_q;
`endif

endmodule

// File: tb/tb_primitive_io_sequencer.sv
// Directed testbench for primitive_io_sequencer with NUM_CH=3,
// SETTLE_CYCLES=4, RST_CYCLES=2. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_primitive_io_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [2:0] cap_req;
    logic [2:0] ibuf_en;
    logic       ff_rst;
    logic [2:0] ff_en;
    logic       ready;
    logic       busy;
`ifdef PRIMITIVE_IO_SEQ_CAPCNT_EN
    logic [15:0] cap_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    primitive_io_sequencer #(
        .NUM_CH       (3),
        .SETTLE_CYCLES(4),
        .RST_CYCLES   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .cap_req  (cap_req),
        .ibuf_en  (ibuf_en),
        .ff_rst   (ff_rst),
        .ff_en    (ff_en),
        .ready    (ready),
        .busy     (busy)
`ifdef PRIMITIVE_IO_SEQ_CAPCNT_EN
        ,
        .cap_count(cap_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ibuf_en"}, 32'(ibuf_en), 32'd0);
        chk({tag, " ff_en"},   32'(ff_en),   32'd0);
        chk({tag, " ff_rst"},  32'(ff_rst),  32'd1);
        chk({tag, " ready"},   32'(ready),   32'd0);
        chk({tag, " busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        logic [2:0] exp_ibuf;

        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cap_req = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b1;
        tick();

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop busy c1", 32'(busy), 32'd0);
        tick();
        chk("start_stop busy c2", 32'(busy), 32'd0);

        // power-up timing: start sampled at cycle 0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned c = 1; c <= 15; c++) begin
            if (c < 3)       exp_ibuf = 3'b000;
            else if (c < 7)  exp_ibuf = 3'b001;
            else if (c < 11) exp_ibuf = 3'b011;
            else             exp_ibuf = 3'b111;
            chk($sformatf("pwr ff_rst c%0d", c),  32'(ff_rst),  32'(c <= 2));
            chk($sformatf("pwr ibuf_en c%0d", c), 32'(ibuf_en), 32'(exp_ibuf));
            chk($sformatf("pwr ready c%0d", c),   32'(ready),   32'(c >= 15));
            chk($sformatf("pwr busy c%0d", c),    32'(busy),    32'd1);
            if (c < 15) tick();
        end

        // round-robin from rr_ptr=0, requesters drop their bit on ack
        cap_req = 3'b111;
        tick();
        chk("rr t+1", 32'(ff_en), 32'b001);
        cap_req = 3'b110;
        tick();
        chk("rr t+2", 32'(ff_en), 32'b010);
        cap_req = 3'b100;
        tick();
        chk("rr t+3", 32'(ff_en), 32'b100);
        cap_req = 3'b000;
        tick();
        chk("rr t+4", 32'(ff_en), 32'b000);

        // single channel held: grant on alternate cycles only
        cap_req = 3'b010;
        tick();
        chk("hold g1", 32'(ff_en), 32'b010);
        tick();
        chk("hold gap1", 32'(ff_en), 32'b000);
        tick();
        chk("hold g2", 32'(ff_en), 32'b010);
        tick();
        chk("hold gap2", 32'(ff_en), 32'b000);
        cap_req = 3'b000;
        tick();
        chk("hold idle", 32'(ff_en), 32'b000);
`ifdef PRIMITIVE_IO_SEQ_CAPCNT_EN
        chk("cap_count 5", 32'(cap_count), 32'd5);
`endif

        // stop in RUN at cycle t
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop t+1 ready",  32'(ready),   32'd0);
        chk("stop t+1 ff_rst", 32'(ff_rst),  32'd1);
        chk("stop t+1 ibuf",   32'(ibuf_en), 32'b011);
        chk("stop t+1 busy",   32'(busy),    32'd1);
        tick();
        chk("stop t+2 ibuf",   32'(ibuf_en), 32'b001);
        tick();
        chk("stop t+3 ibuf",   32'(ibuf_en), 32'b000);
        chk("stop t+3 busy",   32'(busy),    32'd1);
        tick();
        chk("stop t+4 busy",   32'(busy),    32'd0);
        chk("stop t+4 ff_rst", 32'(ff_rst),  32'd1);

        // stop during RESET
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_stop busy c1", 32'(busy), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("rst_stop ibuf c2", 32'(ibuf_en), 32'd0);
        chk("rst_stop busy c2", 32'(busy),    32'd1);
        tick();
        chk("rst_stop ibuf c3", 32'(ibuf_en), 32'd0);
        chk("rst_stop busy c3", 32'(busy),    32'd0);

        // asynchronous reset in the middle of ENABLE
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_en ibuf pre",   32'(ibuf_en), 32'b001);
        chk("mid_en ff_rst pre", 32'(ff_rst),  32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
